// File: rtl/popcount_sequencer.sv
// Serial popcount sequencer: captures i_sw on a button press and counts set bits one per clock.
// Optional debouncer on the button path: define POPCOUNT_SEQUENCER_DEBOUNCE_EN.
module popcount_sequencer #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 1000000,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn,
  input  logic [WIDTH-1:0] i_sw,
  output logic [CW-1:0]    o_cnt,
  output logic             o_parity,
  output logic             o_busy,
  output logic             o_done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("DB_CYCLES must be at least 1");
  end

  state_t           r_state;
  logic             r_sync1, r_sync2, r_prev;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_acc;
  logic [IW-1:0]    r_idx;
  logic             w_level;
  logic             w_start;
  logic [CW-1:0]    w_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef POPCOUNT_SEQUENCER_DEBOUNCE_EN
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [DBW-1:0] r_db_cnt;
  logic           r_db_lvl;

  // Counts consecutive samples disagreeing with the debounced level; any agreement restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_db_cnt <= '0;
      r_db_lvl <= 1'b0;
    end else if (r_sync2 == r_db_lvl) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_db_lvl <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_level = r_db_lvl;
`else
  assign w_level = r_sync2;
`endif

  assign w_start = w_level & ~r_prev;
  assign w_sum   = r_acc + CW'(r_sreg[0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_prev   <= 1'b0;
      r_sreg   <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      o_cnt    <= '0;
      o_parity <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      r_prev <= w_level;
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= LOAD;
            o_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_sreg  <= i_sw;
          r_acc   <= '0;
          r_idx   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_acc  <= w_sum;
          r_sreg <= r_sreg >> 1;
          r_idx  <= r_idx + 1'b1;
          // Result registers only move here, so the display never sees a partial sum.
          if (r_idx == LAST_IDX) begin
            o_cnt    <= w_sum;
            o_parity <= w_sum[0];
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Scoreboard bench for popcount_sequencer: expected counts are queued at press time
// and checked by an independent monitor on every DONE pulse.
module tb_popcount_sequencer;

`ifdef POPCOUNT_SEQUENCER_DEBOUNCE_EN
  localparam int EXTRA = 8;
  localparam int HOLD  = 20;
`else
  localparam int EXTRA = 0;
  localparam int HOLD  = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn = 1'b0;
  logic [15:0] sw  = '0;
  logic [4:0]  cnt;
  logic        parity, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int exp_q[$];

  popcount_sequencer #(.WIDTH(16), .DB_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_sw(sw),
    .o_cnt(cnt), .o_parity(parity), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got cnt %0d with no run pending", cnt);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("cnt", int'(cnt), e);
        check("parity", int'(parity), e % 2);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One press/run; hold_val >= 0 additionally requires the old result to stay visible while busy.
  task automatic run(input logic [15:0] val, input int hold_val);
    int d0, bad;
    d0  = done_seen;
    bad = 0;
    sw  = val;
    btn = 1'b1;
    exp_q.push_back($countones(val));
    for (int i = 1; i <= 60 + EXTRA; i++) begin
      @(negedge clk);
      if (i == HOLD) btn = 1'b0;
      if (hold_val >= 0 && busy && int'(cnt) != hold_val) bad++;
      if (done_seen != d0) break;
    end
    btn = 1'b0;
    cycles(6 + EXTRA);
    check("run_done_count", done_seen - d0, 1);
    if (hold_val >= 0) check("cnt_hold_during_run", bad, 0);
  endtask

  initial begin
    int d0, busy_n, done_at, last;
    logic [15:0] r;

    cycles(3);
    check("reset_cnt", int'(cnt), 0);
    check("reset_parity", int'(parity), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    cycles(3);

    // Latency and BUSY width
    sw = 16'hA5F0;
    btn = 1'b1;
    exp_q.push_back(8);
    d0 = done_seen; busy_n = 0; done_at = 0;
    for (int i = 1; i <= 30 + EXTRA; i++) begin
      @(negedge clk);
      if (i == HOLD) btn = 1'b0;
      if (busy) busy_n++;
      if (done && done_at == 0) done_at = i;
    end
    check("busy_cycles", busy_n, 17);
    check("done_latency", done_at, 20 + EXTRA);
    check("done_pulses", done_seen - d0, 1);
    cycles(6 + EXTRA);

    run(16'hFFFF, -1);
    check("cnt_all_ones", int'(cnt), 16);
    run(16'h0001, 16);

    // Mid-run SW change and extra press are ignored
    sw = 16'h0007;
    btn = 1'b1;
    exp_q.push_back(3);
    d0 = done_seen;
    for (int i = 1; i <= 60 + EXTRA; i++) begin
      @(negedge clk);
      if (i == HOLD) btn = 1'b0;
      if (i == HOLD + 4) begin sw = 16'hFFFF; btn = 1'b1; end
      if (i == HOLD + 6) btn = 1'b0;
    end
    check("single_run_on_midrun_press", done_seen - d0, 1);
    check("cnt_ignores_sw_change", int'(cnt), 3);

    // Long hold gives one run only
    r = 16'($urandom_range(0, 65535));
    sw = r;
    btn = 1'b1;
    exp_q.push_back($countones(r));
    d0 = done_seen;
    cycles(100);
    btn = 1'b0;
    cycles(12 + EXTRA);
    check("held_btn_runs", done_seen - d0, 1);
    run(16'($urandom_range(0, 65535)), -1);

    // Reset mid-run
    run(16'h001F, -1);
    check("cnt_before_abort", int'(cnt), 5);
    sw = 16'hFFFF;
    btn = 1'b1;
    d0 = done_seen;
    for (int i = 1; i <= 12 + EXTRA; i++) begin
      @(negedge clk);
      if (i == HOLD) btn = 1'b0;
    end
    btn = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_cnt", int'(cnt), 0);
    check("abort_parity", int'(parity), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(30 + EXTRA);
    check("abort_no_done", done_seen - d0, 0);
    run(16'h8001, -1);

`ifdef POPCOUNT_SEQUENCER_DEBOUNCE_EN
    // A glitch shorter than the debounce window never starts a run
    d0 = done_seen; busy_n = 0;
    sw = 16'h1234;
    btn = 1'b1;
    cycles(5);
    btn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    check("glitch_no_done", done_seen - d0, 0);
    check("glitch_no_busy", busy_n, 0);
`endif

    // Random runs, each also verifying the previous result holds while busy
    last = int'(cnt);
    for (int k = 0; k < 12; k++) begin
      r = 16'($urandom_range(0, 65535));
      run(r, last);
      last = $countones(r);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
